// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: sequences a valid/ready stream of 7-bit words into frames and folds each
// word into a running x^3+1 remainder, reporting {crc, length, error} per frame.

module crc_unit (
  input  logic [6:0] i_data,
  output logic [2:0] o_crc
);

  // x^3 == 1 modulo the polynomial, so data bit i lands on remainder bit (i mod 3)
  assign o_crc = {i_data[2] ^ i_data[5],
                  i_data[1] ^ i_data[4],
                  i_data[0] ^ i_data[3] ^ i_data[6]};

endmodule

module crc_frame_ctrl #(
  parameter int MAX_WORDS = 16,
  parameter int LEN_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_data,
  input  logic             in_sof,
  input  logic             in_eof,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2:0]       res_crc,
  output logic [LEN_W-1:0] res_len,
  output logic             res_err
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_WORDS);
  localparam logic [LEN_W-1:0] OneLen = LEN_W'(1);

  state_t           r_state;
  logic [2:0]       r_rem;
  logic [LEN_W-1:0] r_len;
  logic             r_err;
  logic             r_drop;
  logic             r_inReady;
  logic             r_resValid;
  logic [2:0]       r_resCrc;
  logic [LEN_W-1:0] r_resLen;
  logic             r_resErr;

  logic [2:0]       w_crc;
  logic [2:0]       w_fold;
  logic [2:0]       w_remNext;
  logic [LEN_W-1:0] w_lenNext;
  logic             w_errNext;
  logic             w_beat;

  crc_unit u_crc (
    .i_data (in_data),
    .o_crc  (w_crc)
  );

  assign w_beat = in_valid & r_inReady;
  assign w_fold = {r_rem[1], r_rem[0], r_rem[2]} ^ w_crc;

  // A SOF restarts the frame; a SOF arriving mid-frame marks the restarted frame as errored
  always_comb begin
    w_remNext = w_fold;
    w_lenNext = r_len;
    w_errNext = r_err;
    if (in_sof) begin
      w_remNext = w_crc;
      w_lenNext = OneLen;
      w_errNext = (r_state == IDLE) ? r_drop : 1'b1;
    end else if (r_len == MaxLen) begin
      w_errNext = 1'b1;
    end else begin
      w_lenNext = r_len + OneLen;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rem      <= '0;
      r_len      <= '0;
      r_err      <= 1'b0;
      r_drop     <= 1'b0;
      r_inReady  <= 1'b0;
      r_resValid <= 1'b0;
      r_resCrc   <= '0;
      r_resLen   <= '0;
      r_resErr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_inReady <= 1'b1;
          if (w_beat && !in_sof) begin
            r_drop <= 1'b1;
          end else if (w_beat) begin
            r_rem <= w_remNext;
            r_len <= w_lenNext;
            r_err <= w_errNext;
            if (in_eof) begin
              r_state    <= DONE;
              r_inReady  <= 1'b0;
              r_resValid <= 1'b1;
              r_resCrc   <= w_remNext;
              r_resLen   <= w_lenNext;
              r_resErr   <= w_errNext;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_beat) begin
            r_rem <= w_remNext;
            r_len <= w_lenNext;
            r_err <= w_errNext;
            if (in_eof) begin
              r_state    <= DONE;
              r_inReady  <= 1'b0;
              r_resValid <= 1'b1;
              r_resCrc   <= w_remNext;
              r_resLen   <= w_lenNext;
              r_resErr   <= w_errNext;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            r_state    <= IDLE;
            r_resValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_drop     <= 1'b0;
            r_rem      <= '0;
            r_len      <= '0;
            r_err      <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_inReady <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign res_valid = r_resValid;
  assign res_crc   = r_resCrc;
  assign res_len   = r_resLen;
  assign res_err   = r_resErr;

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// tb_crc_frame_ctrl: directed and randomized frames against a bit-serial x^3+1 long-division
// model of the whole frame message.

module tb_crc_frame_ctrl;

  localparam int MAXW = 4;
  localparam int LW   = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          in_eof = 1'b0;
  logic          res_ready = 1'b0;
  logic [6:0]    in_data = '0;
  logic          in_ready;
  logic          res_valid;
  logic          res_err;
  logic [2:0]    res_crc;
  logic [LW-1:0] res_len;

  int checks = 0;
  int errors = 0;

  logic [6:0]    mWords[$];
  logic          mInFrame = 1'b0;
  logic          mDrop = 1'b0;
  logic          mErr = 1'b0;
  logic [2:0]    expCrc = '0;
  logic [LW-1:0] expLen = '0;
  logic          expErr = 1'b0;

  always #5 clk = ~clk;

  crc_frame_ctrl #(
    .MAX_WORDS (MAXW),
    .LEN_W     (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .in_eof    (in_eof),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_crc   (res_crc),
    .res_len   (res_len),
    .res_err   (res_err)
  );

  // Whole frame treated as one message polynomial, divided MSB-first by x^3+1
  function automatic logic [2:0] goldenCrc();
    logic [3:0] r;
    r = '0;
    foreach (mWords[i]) begin
      for (int b = 6; b >= 0; b--) begin
        r = {r[2:0], mWords[i][b]};
        if (r[3]) r = r ^ 4'b1001;
      end
    end
    return r[2:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelBeat(input logic [6:0] d, input logic sof, input logic eof);
    if (!mInFrame && !sof) begin
      mDrop = 1'b1;
    end else begin
      if (sof) begin
        mErr = mInFrame ? 1'b1 : mDrop;
        mWords.delete();
        mInFrame = 1'b1;
      end
      mWords.push_back(d);
      if (eof) begin
        expCrc   = goldenCrc();
        expLen   = (mWords.size() > MAXW) ? LW'(MAXW) : LW'(mWords.size());
        expErr   = mErr | (mWords.size() > MAXW);
        mInFrame = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input logic [6:0] d, input logic sof, input logic eof);
    int waitCycles = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    in_eof   = eof;
    while (!in_ready && waitCycles < 50) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $error("[TB] FAIL in_ready_timeout: observed=0 expected=1");
    end else begin
      @(posedge clk);
      #1;
      modelBeat(d, sof, eof);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    in_data  = 7'($urandom);
  endtask

  task automatic checkConst(input string tag, input logic [2:0] c, input logic [LW-1:0] l,
                            input logic e);
    checkOutput({tag, "_crc_const"}, 8'(res_crc), 8'(c));
    checkOutput({tag, "_len_const"}, 8'(res_len), 8'(l));
    checkOutput({tag, "_err_const"}, 8'(res_err), 8'(e));
  endtask

  task automatic collectResult(input string tag, input int hold);
    int waitCycles = 0;
    while (!res_valid && waitCycles < 50) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    if (!res_valid) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s_res_timeout: observed=0 expected=1", tag);
      return;
    end
    checkOutput({tag, "_crc"}, 8'(res_crc), 8'(expCrc));
    checkOutput({tag, "_len"}, 8'(res_len), 8'(expLen));
    checkOutput({tag, "_err"}, 8'(res_err), 8'(expErr));
    repeat (hold) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_hold_valid"}, 8'(res_valid), 8'd1);
      checkOutput({tag, "_hold_ready"}, 8'(in_ready), 8'd0);
      checkOutput({tag, "_hold_crc"}, 8'(res_crc), 8'(expCrc));
      checkOutput({tag, "_hold_len"}, 8'(res_len), 8'(expLen));
      checkOutput({tag, "_hold_err"}, 8'(res_err), 8'(expErr));
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    mDrop = 1'b0;
    checkOutput({tag, "_released"}, 8'(res_valid), 8'd0);
  endtask

  task automatic resetDut(input string tag);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    mInFrame = 1'b0;
    mDrop    = 1'b0;
    mWords.delete();
    #2;
    checkOutput({tag, "_in_ready"}, 8'(in_ready), 8'd0);
    checkOutput({tag, "_res_valid"}, 8'(res_valid), 8'd0);
    checkOutput({tag, "_res_crc"}, 8'(res_crc), 8'd0);
    checkOutput({tag, "_res_len"}, 8'(res_len), 8'd0);
    checkOutput({tag, "_res_err"}, 8'(res_err), 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput({tag, "_ready_held"}, 8'(in_ready), 8'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_ready_rise"}, 8'(in_ready), 8'd1);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    #1;
    resetDut("init");

    applyStimulus(7'h49, 1'b1, 1'b1);
    checkOutput("t1_latency", 8'(res_valid), 8'd1);
    checkConst("t1", 3'b001, LW'(1), 1'b0);
    collectResult("t1", 0);

    applyStimulus(7'h01, 1'b1, 1'b0);
    applyStimulus(7'h00, 1'b0, 1'b1);
    checkConst("t2", 3'b010, LW'(2), 1'b0);
    collectResult("t2", 0);

    applyStimulus(7'h2A, 1'b1, 1'b1);
    in_valid = 1'b1;
    in_data  = 7'h49;
    in_sof   = 1'b1;
    in_eof   = 1'b1;
    collectResult("t3", 5);
    checkOutput("t3_ready_after_release", 8'(in_ready), 8'd1);
    applyStimulus(7'h49, 1'b1, 1'b1);
    checkConst("t3_pending", 3'b001, LW'(1), 1'b0);
    collectResult("t3_pending", 0);

    for (int k = 0; k < 5; k++) applyStimulus(7'h00, k == 0, k == 4);
    checkConst("t4_long", 3'b000, LW'(4), 1'b1);
    collectResult("t4_long", 1);
    for (int k = 0; k < 4; k++) applyStimulus(7'h00, k == 0, k == 3);
    checkConst("t4_max", 3'b000, LW'(4), 1'b0);
    collectResult("t4_max", 0);

    applyStimulus(7'h7F, 1'b0, 1'b0);
    applyStimulus(7'h49, 1'b1, 1'b1);
    checkConst("t5_drop", 3'b001, LW'(1), 1'b1);
    collectResult("t5_drop", 0);
    applyStimulus(7'h01, 1'b1, 1'b0);
    applyStimulus(7'h00, 1'b0, 1'b1);
    checkConst("t5_clean", 3'b010, LW'(2), 1'b0);
    collectResult("t5_clean", 0);

    applyStimulus(7'h15, 1'b1, 1'b0);
    applyStimulus(7'h33, 1'b0, 1'b0);
    applyStimulus(7'h01, 1'b1, 1'b0);
    applyStimulus(7'h00, 1'b0, 1'b1);
    checkConst("restart", 3'b010, LW'(2), 1'b1);
    collectResult("restart", 0);

    applyStimulus(7'h22, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 7'h11;
    #1;
    resetDut("t6_mid");
    for (int k = 0; k < 3; k++) applyStimulus(7'($urandom), k == 0, k == 2);
    checkOutput("t6_mid_err", 8'(res_err), 8'd0);
    collectResult("t6_mid", 0);

    applyStimulus(7'h5C, 1'b1, 1'b1);
    checkOutput("t6_done_valid", 8'(res_valid), 8'd1);
    #2;
    resetDut("t6_done");
    for (int k = 0; k < 3; k++) applyStimulus(7'($urandom), k == 0, k == 2);
    checkOutput("t6_done_err", 8'(res_err), 8'd0);
    collectResult("t6_after", 0);

    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, MAXW + 1);
      repeat ($urandom_range(0, 2)) begin
        in_sof  = 1'($urandom);
        in_eof  = 1'($urandom);
        in_data = 7'($urandom);
        @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 5) == 0) applyStimulus(7'($urandom), 1'b0, 1'b0);
      for (int k = 0; k < n; k++) applyStimulus(7'($urandom), k == 0, k == n - 1);
      collectResult("rand", $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
